downcount_progress: RTL and testbench

- Parametrised countdown timer with segmented progress bar for the number game.
- Counts SEGMENTS × difficulty seconds on secclk, one count per clock edge.
- Exposes remaining seconds, a ceil-scaled progress level, run/pause control, a done flag and a timeout pulse.
- Sits between the difficulty selector and the LED/7-seg progress display; game FSM consumes timeout/done.

---
 rtl/downcount_progress.sv | 169 ++++++++++++++++
 tb/tb_downcount_progress.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/downcount_progress.sv
// downcount_progress: countdown timer with a segmented progress bar.
// Counts SEGMENTS*difficulty seconds on secclk, one count per rising edge.
// Progress is ceil(remaining/d_lat) and is tracked with a sub-segment
// counter, so no divider is needed.
// The optional low-time warning is built only when DOWNCOUNT_WARN_EN is
// defined. Without it, warn is tied low.
//
// Ports:
//   secclk     in   one-second clock; all state changes on its rising edge
//   reset      in   synchronous active-high reset
//   start      in   load or restart the countdown
//   pause      in   holds the count while high
//   difficulty in   seconds per segment, latched on start (0 is treated as 1)
//   progress   out  number of lit bar segments, ceil(remaining/d_lat)
//   remaining  out  seconds left
//   running    out  high in the RUN state
//   done       out  high from expiry until the next start or reset
//   timeout    out  one-cycle pulse on expiry
//   warn       out  low-time warning
module downcount_progress #(
   parameter int unsigned SEGMENTS   = 10,
   parameter int unsigned DIFF_W     = 4,
   parameter int unsigned PROG_W     = 5,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned WARN_LEVEL = 3
) (
   input  logic              secclk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic [DIFF_W-1:0] difficulty,
   output logic [PROG_W-1:0] progress,
   output logic [CNT_W-1:0]  remaining,
   output logic              running,
   output logic              done,
   output logic              timeout,
   output logic              warn
);

   // Elaboration-time checks on the parameters.
   if (PROG_W < $clog2(SEGMENTS + 1)) begin : g_chk_prog
      $error("PROG_W too narrow for SEGMENTS");
   end
   if (CNT_W < $clog2(SEGMENTS * ((1 << DIFF_W) - 1) + 1)) begin : g_chk_cnt
      $error("CNT_W too narrow for SEGMENTS*(2^DIFF_W-1)");
   end
   if (WARN_LEVEL > SEGMENTS) begin : g_chk_warn
      $error("WARN_LEVEL exceeds SEGMENTS");
   end

   typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    remaining_q, remaining_d;
   logic [PROG_W-1:0]   progress_q, progress_d;
   logic [DIFF_W-1:0]   dlat_q, dlat_d;
   logic [DIFF_W-1:0]   sub_q, sub_d;
   logic                running_q, running_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      progress_d  = progress_q;
      dlat_d      = dlat_q;
      sub_d       = sub_q;
      running_d   = running_q;
      done_d      = done_q;
      timeout_d   = 1'b0;

      if (start) begin
         dlat_d      = (difficulty == '0) ? DIFF_W'(1) : difficulty;
         remaining_d = CNT_W'(SEGMENTS) * CNT_W'(dlat_d);
         progress_d  = PROG_W'(SEGMENTS);
         sub_d       = dlat_d;
         done_d      = 1'b0;
         state_d     = StRun;
         running_d   = 1'b1;
      end else begin
         unique case (state_q)
            StRun: begin
               if (pause) begin
                  state_d   = StPaused;
                  running_d = 1'b0;
               end else if (remaining_q != '0) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  // sub counts the seconds left in the current segment.
                  if (sub_q == DIFF_W'(1)) begin
                     progress_d = progress_q - PROG_W'(1);
                     sub_d      = dlat_q;
                  end else begin
                     sub_d = sub_q - DIFF_W'(1);
                  end
                  if (remaining_q == CNT_W'(1)) begin
                     progress_d = '0;
                     state_d    = StExpired;
                     running_d  = 1'b0;
                     done_d     = 1'b1;
                     timeout_d  = 1'b1;
                  end
               end
            end
            StPaused: begin
               // The release edge only changes state; counting resumes one edge later.
               if (!pause) begin
                  state_d   = StRun;
                  running_d = 1'b1;
               end
            end
            default: ;  // IDLE and EXPIRED hold until start or reset
         endcase
      end
   end

   always_ff @(posedge secclk) begin
      if (reset) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         progress_q  <= PROG_W'(SEGMENTS);
         dlat_q      <= DIFF_W'(1);
         sub_q       <= DIFF_W'(1);
         running_q   <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         progress_q  <= progress_d;
         dlat_q      <= dlat_d;
         sub_q       <= sub_d;
         running_q   <= running_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
      end
   end

   assign progress  = progress_q;
   assign remaining = remaining_q;
   assign running   = running_q;
   assign done      = done_q;
   assign timeout   = timeout_q;

`ifdef DOWNCOUNT_WARN_EN
   logic warn_q, warn_d;

   // Computed from next-state values so warn moves on the same edge as progress.
   always_comb begin
      warn_d = ((state_d == StRun) || (state_d == StPaused)) &&
               (progress_d <= PROG_W'(WARN_LEVEL)) && (progress_d != '0);
      if (start) begin
         warn_d = 1'b0;
      end
   end

   always_ff @(posedge secclk) begin
      if (reset) begin
         warn_q <= 1'b0;
      end else begin
         warn_q <= warn_d;
      end
   end

   assign warn = warn_q;
`else
   assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_downcount_progress.sv
module tb_downcount_progress;

   logic       secclk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic [3:0] difficulty;
   logic [4:0] progress;
   logic [7:0] remaining;
   logic       running;
   logic       done;
   logic       timeout;
   logic       warn;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef DOWNCOUNT_WARN_EN
   localparam logic WE = 1'b1;
`else
   localparam logic WE = 1'b0;
`endif

   downcount_progress dut (
      .secclk     (secclk),
      .reset      (reset),
      .start      (start),
      .pause      (pause),
      .difficulty (difficulty),
      .progress   (progress),
      .remaining  (remaining),
      .running    (running),
      .done       (done),
      .timeout    (timeout),
      .warn       (warn)
   );

   always #5 secclk = ~secclk;

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge secclk);
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int rem, input int prog, input logic run,
                          input logic dn, input logic to, input logic wr);
      chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
      chk({tag, ".progress"},  32'(progress),  32'(prog));
      chk({tag, ".running"},   32'(running),   32'(run));
      chk({tag, ".done"},      32'(done),      32'(dn));
      chk({tag, ".timeout"},   32'(timeout),   32'(to));
      chk({tag, ".warn"},      32'(warn),      32'(wr));
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; difficulty = 4'd0;
      step(2);
      reset = 1'b0;
      chk_all("reset", 0, 10, 0, 0, 0, 0);

      // IDLE ignores pause
      pause = 1'b1;
      step(2);
      pause = 1'b0;
      chk_all("idle_hold", 0, 10, 0, 0, 0, 0);

      // difficulty 3: load, then partial progress steps
      difficulty = 4'd3; start = 1'b1;
      step(1);
      start = 1'b0; difficulty = 4'd9;  // ignored outside a start edge
      chk_all("d3_load", 30, 10, 1, 0, 0, 0);
      step(1);
      chk_all("d3_e1", 29, 10, 1, 0, 0, 0);
      step(2);
      chk_all("d3_e3", 27, 9, 1, 0, 0, 0);
      step(1);
      chk_all("d3_e4", 26, 9, 1, 0, 0, 0);
      step(25);
      chk_all("d3_e29", 1, 1, 1, 0, 0, WE);
      step(1);
      chk_all("d3_expire", 0, 0, 0, 1, 1, 0);
      step(1);
      chk_all("d3_post1", 0, 0, 0, 1, 0, 0);
      pause = 1'b1;
      step(2);
      pause = 1'b0;
      chk_all("d3_hold", 0, 0, 0, 1, 0, 0);

      // difficulty 0 behaves as 1
      difficulty = 4'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("d0_load", 10, 10, 1, 0, 0, 0);
      step(1);
      chk_all("d0_e1", 9, 9, 1, 0, 0, 0);
      step(8);
      chk_all("d0_e9", 1, 1, 1, 0, 0, WE);
      step(1);
      chk_all("d0_expire", 0, 0, 0, 1, 1, 0);

      // difficulty 2 with a 4-edge pause
      difficulty = 4'd2; start = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("d2_load", 20, 10, 1, 0, 0, 0);
      step(5);
      chk_all("d2_e5", 15, 8, 1, 0, 0, 0);
      pause = 1'b1;
      step(1);
      chk_all("d2_pause1", 15, 8, 0, 0, 0, 0);
      step(3);
      chk_all("d2_pause4", 15, 8, 0, 0, 0, 0);
      pause = 1'b0;
      step(1);
      chk_all("d2_release", 15, 8, 1, 0, 0, 0);
      step(1);
      chk_all("d2_resume", 14, 7, 1, 0, 0, 0);
      step(13);
      chk_all("d2_rem1", 1, 1, 1, 0, 0, WE);
      step(1);
      chk_all("d2_expire", 0, 0, 0, 1, 1, 0);

      // start and pause on the same edge: start wins
      difficulty = 4'd2; start = 1'b1; pause = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("sp_start", 20, 10, 1, 0, 0, 0);
      step(1);
      chk_all("sp_paused", 20, 10, 0, 0, 0, 0);
      pause = 1'b0;
      step(1);
      chk_all("sp_release", 20, 10, 1, 0, 0, 0);
      step(1);
      chk_all("sp_count", 19, 10, 1, 0, 0, 0);

      // restart mid-run, then reset mid-run
      difficulty = 4'd4; start = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("d4_load", 40, 10, 1, 0, 0, 0);
      step(7);
      chk_all("d4_e7", 33, 9, 1, 0, 0, 0);
      difficulty = 4'd1; start = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("restart", 10, 10, 1, 0, 0, 0);
      step(1);
      chk_all("restart_e1", 9, 9, 1, 0, 0, 0);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk_all("reset_mid", 0, 10, 0, 0, 0, 0);
      step(1);
      chk_all("reset_hold", 0, 10, 0, 0, 0, 0);

      // difficulty 1: warn window
      difficulty = 4'd1; start = 1'b1;
      step(1);
      start = 1'b0;
      chk_all("w_load", 10, 10, 1, 0, 0, 0);
      step(6);
      chk_all("w_p4", 4, 4, 1, 0, 0, 0);
      step(1);
      chk_all("w_p3", 3, 3, 1, 0, 0, WE);
      step(1);
      chk_all("w_p2", 2, 2, 1, 0, 0, WE);
      step(1);
      chk_all("w_p1", 1, 1, 1, 0, 0, WE);
      step(1);
      chk_all("w_expire", 0, 0, 0, 1, 1, 0);
      step(1);
      chk_all("w_post", 0, 0, 0, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
